// File: rtl/seven_segment_pkg.sv
// Shared definitions for the 7-segment read-back path: active-low glyph
// patterns (bit0=a .. bit6=g) and the stability FSM encoding.
package seven_segment_pkg;

    localparam logic [6:0] SEG_0     = 7'h40;
    localparam logic [6:0] SEG_1     = 7'h79;
    localparam logic [6:0] SEG_2     = 7'h24;
    localparam logic [6:0] SEG_3     = 7'h30;
    localparam logic [6:0] SEG_4     = 7'h19;
    localparam logic [6:0] SEG_5     = 7'h12;
    localparam logic [6:0] SEG_6     = 7'h02;
    localparam logic [6:0] SEG_7     = 7'h78;
    localparam logic [6:0] SEG_8     = 7'h00;
    localparam logic [6:0] SEG_9     = 7'h10;
    localparam logic [6:0] SEG_A     = 7'h08;
    localparam logic [6:0] SEG_B     = 7'h03;
    localparam logic [6:0] SEG_C     = 7'h46;
    localparam logic [6:0] SEG_D     = 7'h21;
    localparam logic [6:0] SEG_E     = 7'h06;
    localparam logic [6:0] SEG_F     = 7'h0E;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    typedef enum logic {
        SETTLE = 1'b0,
        STABLE = 1'b1
    } state_t;

endpackage

// File: rtl/seven_segment_lookup.sv
// Combinational reverse glyph lookup: active-low segment pattern to hex code,
// with hex-glyph and all-off classification.
module seven_segment_lookup
    import seven_segment_pkg::*;
(
    input  logic [6:0] pattern,
    output logic [3:0] code,
    output logic       is_hex,
    output logic       is_blank
);

    always_comb begin
        // NOTE: every output gets a default before the case so no path can infer a latch.
        code     = 4'h0;
        is_hex   = 1'b1;
        is_blank = 1'b0;
        case (pattern)
            SEG_0: code = 4'h0;
            SEG_1: code = 4'h1;
            SEG_2: code = 4'h2;
            SEG_3: code = 4'h3;
            SEG_4: code = 4'h4;
            SEG_5: code = 4'h5;
            SEG_6: code = 4'h6;
            SEG_7: code = 4'h7;
            SEG_8: code = 4'h8;
            SEG_9: code = 4'h9;
            SEG_A: code = 4'hA;
            SEG_B: code = 4'hB;
            SEG_C: code = 4'hC;
            SEG_D: code = 4'hD;
            SEG_E: code = 4'hE;
            SEG_F: code = 4'hF;
            SEG_BLANK: begin
                is_hex   = 1'b0;
                is_blank = 1'b1;
            end
            default: is_hex = 1'b0;
        endcase
    end

endmodule

// File: rtl/seven_segment_encoder.sv
// Samples an asynchronous active-low 7-segment bus, debounces it and recovers
// the displayed hex digit; each newly settled pattern is offered as an event.
module seven_segment_encoder
    import seven_segment_pkg::*;
#(
    parameter int STABLE_CYCLES = 4
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [6:0] seg_in,
    input  logic       ev_ready,
    input  logic       clr_overrun,
    output logic [3:0] hex_out,
    output logic       hex_valid,
    output logic       blank,
    output logic       invalid,
    output logic       locked,
    output logic       ev_valid,
    output logic [3:0] ev_code,
    output logic       ev_blank,
    output logic       ev_invalid,
    output logic       overrun
);

    localparam int             CNT_W    = $clog2(STABLE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

    logic [6:0]       s1, seg_s;
    logic [6:0]       cand, cand_n;
    logic [6:0]       committed;
    logic [CNT_W-1:0] cnt, cnt_n;
    state_t           state, state_n;
    logic             do_commit;

    logic [3:0]       lk_code;
    logic             lk_is_hex, lk_is_blank;
    logic [3:0]       new_code;
    logic             new_invalid;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            s1    <= SEG_BLANK;
            seg_s <= SEG_BLANK;
        end else begin
            // NOTE: non-blocking so s1 and seg_s form a true two-stage synchroniser.
            s1    <= seg_in;
            seg_s <= s1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= SETTLE;
            cnt   <= '0;
            cand  <= SEG_BLANK;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            cand  <= cand_n;
        end
    end

    // A glitch that settles back onto the committed pattern relocks silently.
    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        cand_n    = cand;
        do_commit = 1'b0;
        if (seg_s != cand) begin
            cand_n  = seg_s;
            cnt_n   = CNT_W'(1);
            state_n = SETTLE;
        end else if (state == SETTLE) begin
            if (cnt == CNT_LAST) begin
                state_n   = STABLE;
                do_commit = (cand != committed);
            end else begin
                cnt_n = cnt + 1'b1;
            end
        end
    end

    assign locked = (state == STABLE);

    seven_segment_lookup u_lookup (
        .pattern  (cand),
        .code     (lk_code),
        .is_hex   (lk_is_hex),
        .is_blank (lk_is_blank)
    );

    assign new_code    = lk_is_hex ? lk_code : 4'h0;
    assign new_invalid = !lk_is_hex && !lk_is_blank;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            committed <= SEG_BLANK;
            hex_out   <= 4'h0;
            hex_valid <= 1'b0;
            blank     <= 1'b1;
            invalid   <= 1'b0;
        end else if (do_commit) begin
            committed <= cand;
            hex_out   <= new_code;
            hex_valid <= lk_is_hex;
            blank     <= lk_is_blank;
            invalid   <= new_invalid;
        end
    end

    // One-deep event buffer: accept and refill may share an edge; a commit
    // that finds the buffer blocked is dropped and flagged.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ev_valid   <= 1'b0;
            ev_code    <= 4'h0;
            ev_blank   <= 1'b0;
            ev_invalid <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            if (do_commit && (!ev_valid || ev_ready)) begin
                ev_valid   <= 1'b1;
                ev_code    <= new_code;
                ev_blank   <= lk_is_blank;
                ev_invalid <= new_invalid;
            end else if (ev_valid && ev_ready) begin
                ev_valid <= 1'b0;
            end

            if (do_commit && ev_valid && !ev_ready) begin
                overrun <= 1'b1;
            end else if (clr_overrun) begin
                overrun <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_seven_segment_encoder.sv
// Directed bench for seven_segment_encoder: level outputs checked at fixed
// latencies, events checked against a queue of expected payloads.
module tb_seven_segment_encoder;

    logic       clock;
    logic       reset;
    logic [6:0] seg_in;
    logic       ev_ready;
    logic       clr_overrun;
    logic [3:0] hex_out;
    logic       hex_valid;
    logic       blank;
    logic       invalid;
    logic       locked;
    logic       ev_valid;
    logic [3:0] ev_code;
    logic       ev_blank;
    logic       ev_invalid;
    logic       overrun;

    typedef struct packed {
        logic [3:0] code;
        logic       blank;
        logic       invalid;
    } ev_t;

    ev_t exp_q[$];
    int  n_checks = 0;
    int  n_fail   = 0;

    seven_segment_encoder #(.STABLE_CYCLES(4)) dut (
        .clock       (clock),
        .reset       (reset),
        .seg_in      (seg_in),
        .ev_ready    (ev_ready),
        .clr_overrun (clr_overrun),
        .hex_out     (hex_out),
        .hex_valid   (hex_valid),
        .blank       (blank),
        .invalid     (invalid),
        .locked      (locked),
        .ev_valid    (ev_valid),
        .ev_code     (ev_code),
        .ev_blank    (ev_blank),
        .ev_invalid  (ev_invalid),
        .overrun     (overrun)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance n rising edges and land 1 ns after the last one.
    task automatic step(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic expect_event(input logic [3:0] code, input logic blnk, input logic inv);
        ev_t e;
        e.code    = code;
        e.blank   = blnk;
        e.invalid = inv;
        exp_q.push_back(e);
    endtask

    // Wait (bounded) for a pending event, compare it with the oldest
    // expectation, then handshake it away.
    task automatic consume(input string tag);
        ev_t e;
        for (int i = 0; i < 20 && !ev_valid; i++) step(1);
        check({tag, "_valid"}, ev_valid, 1);
        if (ev_valid) begin
            if (exp_q.size() == 0) begin
                check({tag, "_unexpected"}, ev_valid, 0);
            end else begin
                e = exp_q.pop_front();
                check({tag, "_payload"}, {ev_code, ev_blank, ev_invalid}, e);
            end
            ev_ready = 1'b1;
            step(1);
            ev_ready = 1'b0;
            check({tag, "_drained"}, ev_valid, 0);
        end
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_hex_out"}, hex_out, 0);
        check({tag, "_hex_valid"}, hex_valid, 0);
        check({tag, "_blank"}, blank, 1);
        check({tag, "_invalid"}, invalid, 0);
        check({tag, "_locked"}, locked, 0);
        check({tag, "_ev_valid"}, ev_valid, 0);
        check({tag, "_ev_code"}, ev_code, 0);
        check({tag, "_ev_blank"}, ev_blank, 0);
        check({tag, "_ev_invalid"}, ev_invalid, 0);
        check({tag, "_overrun"}, overrun, 0);
    endtask

    initial begin
        reset       = 1'b1;
        seg_in      = 7'h7F;
        ev_ready    = 1'b0;
        clr_overrun = 1'b0;
        #1;
        check_reset_values("rst");
        step(2);
        reset = 1'b0;

        // Idle blank bus: locks without producing an event.
        step(6);
        check("idle_blank", blank, 1);
        check("idle_hex_valid", hex_valid, 0);
        check("idle_ev_valid", ev_valid, 0);
        check("idle_locked", locked, 1);

        // 7F -> 24: commit exactly at edge STABLE_CYCLES+2.
        seg_in = 7'h24;
        expect_event(4'h2, 1'b0, 1'b0);
        step(5);
        check("lat_early_ev_valid", ev_valid, 0);
        check("lat_early_hex_valid", hex_valid, 0);
        step(1);
        check("lat_hex_out", hex_out, 4'h2);
        check("lat_hex_valid", hex_valid, 1);
        check("lat_ev_valid", ev_valid, 1);
        check("lat_ev_code", ev_code, 4'h2);
        consume("ev2");

        // Two-cycle glitch to 30 and back to 24: relock, no event.
        seg_in = 7'h30;
        step(2);
        seg_in = 7'h24;
        step(2);
        check("glitch_unlocked", locked, 0);
        step(10);
        check("glitch_relocked", locked, 1);
        check("glitch_hex_out", hex_out, 4'h2);
        check("glitch_no_event", ev_valid, 0);

        // Event 3 held pending, commit of 5 is dropped.
        seg_in = 7'h30;
        expect_event(4'h3, 1'b0, 1'b0);
        step(6);
        check("ovr_ev3_valid", ev_valid, 1);
        check("ovr_hex_out3", hex_out, 4'h3);
        seg_in = 7'h12;
        step(6);
        check("ovr_hex_out5", hex_out, 4'h5);
        check("ovr_ev_code_held", ev_code, 4'h3);
        check("ovr_flag", overrun, 1);
        clr_overrun = 1'b1;
        step(1);
        clr_overrun = 1'b0;
        check("ovr_cleared", overrun, 0);
        consume("ev3");

        // Illegal pattern, then F.
        seg_in = 7'h55;
        expect_event(4'h0, 1'b0, 1'b1);
        step(6);
        check("inv_invalid", invalid, 1);
        check("inv_hex_valid", hex_valid, 0);
        check("inv_hex_out", hex_out, 4'h0);
        check("inv_blank", blank, 0);
        consume("ev_inv");
        seg_in = 7'h0E;
        expect_event(4'hF, 1'b0, 1'b0);
        step(6);
        check("f_hex_out", hex_out, 4'hF);
        check("f_hex_valid", hex_valid, 1);
        check("f_invalid", invalid, 0);
        consume("evF");

        // Back to blank: a blank event.
        seg_in = 7'h7F;
        expect_event(4'h0, 1'b1, 1'b0);
        step(6);
        check("blk_blank", blank, 1);
        check("blk_hex_valid", hex_valid, 0);
        consume("ev_blank");

        // Pending event plus mid-SETTLE reset: everything discarded.
        seg_in = 7'h24;
        step(6);
        check("mid_ev_valid", ev_valid, 1);
        seg_in = 7'h40;
        step(3);
        check("mid_settle", locked, 0);
        #2;
        reset = 1'b1;
        #1;
        check_reset_values("mid_rst");
        seg_in = 7'h7F;
        step(2);
        reset = 1'b0;
        step(10);
        check("post_rst_ev_valid", ev_valid, 0);
        check("post_rst_blank", blank, 1);
        check("post_rst_locked", locked, 1);
        check("post_rst_hex_valid", hex_valid, 0);
        check("sb_empty", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/seven_segment_encoder.md
Name: seven_segment_encoder

Overview:
Reverse path of the hex-to-segment decoder. It samples an active-low 7-segment bus, synchronises and debounces it, and recovers the 4-bit hex digit being displayed. Each newly settled pattern is emitted as an event on a one-deep valid/ready output. It also flags blank and non-hex patterns. Used to read back or monitor external display drivers in the same board-level designs.

Parameters:
STABLE_CYCLES, 4, consecutive synchronised cycles a pattern must hold before it is committed (min 2).
CNT_W, $clog2(STABLE_CYCLES+1), stability counter width (derived, not overridden).

Ports:
clock  input  1  system clock, all state on rising edge
reset  input  1  asynchronous, active-high reset
seg_in  input  7  async segment bus, active-low, bit0=a … bit6=g
ev_ready  input  1  consumer accepts event
clr_overrun  input  1  synchronous clear of overrun flag
hex_out  output  4  committed digit (0 when blank/invalid)
hex_valid  output  1  committed pattern is a legal hex glyph
blank  output  1  committed pattern is all-off (7'h7F)
invalid  output  1  committed pattern neither hex glyph nor blank
locked  output  1  FSM in STABLE state
ev_valid  output  1  event pending
ev_code  output  4  event digit
ev_blank  output  1  event is blank
ev_invalid  output  1  event is illegal pattern
overrun  output  1  sticky: commit dropped while event pending

Behaviour:
- Glyph table, active-low g..a:
  - 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78
  - 8=00, 9=10, A=08, b=03, C=46, d=21, E=06, F=0E
  - blank=7F; any other code is invalid.
- Reset values:
  - sync flops, candidate and committed pattern = 7'h7F; counter = 0; FSM = SETTLE.
  - hex_out=0, hex_valid=0, blank=1, invalid=0, locked=0.
  - ev_valid=0, ev_code=0, ev_blank=0, ev_invalid=0, overrun=0.
- Synchroniser: two flops, s1 then seg_s; seg_in is not used anywhere else.
- Stability tracking:
  - If seg_s != candidate: candidate←seg_s, cnt←1, FSM→SETTLE.
  - Else if FSM=SETTLE: when cnt==STABLE_CYCLES-1, commit and FSM→STABLE; otherwise cnt++.
  - In STABLE, cnt holds.
- Commit:
  - If the candidate equals the committed pattern, only FSM→STABLE (no event). This covers a glitch returning to the old value.
  - Otherwise update committed pattern, hex_out, hex_valid, blank and invalid at the same edge, and generate an event.
- Latency: seg_in changes before edge 1 and is then held. seg_s updates at edge 2, candidate loads at edge 3, commit occurs at edge STABLE_CYCLES+2. Level outputs and ev_valid are high after that edge.
- Event buffer:
  - Payload is held constant while ev_valid && !ev_ready.
  - ev_valid && ev_ready at an edge with no commit: ev_valid←0.
  - Commit and (ev_valid==0 or ev_ready==1): load new payload, ev_valid←1. Accept and refill happen in the same edge.
  - Commit while ev_valid && !ev_ready: new event is dropped, overrun←1. Level outputs still update.
  - clr_overrun clears overrun; a simultaneous drop wins (overrun stays 1).
- Any seg_s change during SETTLE restarts the count. Level outputs keep the previous committed value until the next commit.
- Asynchronous reset mid-operation returns every output to its reset value immediately. The pending event is discarded.

Decomposition:
- Package seven_segment_pkg: SEG_0…SEG_F glyph localparams, SEG_BLANK=7'h7F, FSM state encoding (SETTLE, STABLE).
- Sub-module seven_segment_lookup: combinational pattern[6:0] → code[3:0], is_hex, is_blank. It is a case over the package constants and is shared with future display monitors.

Test Plan:
- Reset, then hold seg_in=7F: blank=1, hex_valid=0, ev_valid stays 0, locked=1 after edge 6.
- seg_in 7F→24, STABLE_CYCLES=4, ev_ready=0: after edge 6, hex_out=2, hex_valid=1, ev_valid=1, ev_code=2. It must not be asserted after edge 5.
- Glitch: from committed 24, drive 30 for 2 cycles then back to 24: no event, hex_out stays 2, locked drops during SETTLE and then returns to 1.
- ev_ready=0 with event 3 pending, then commit 12: ev_code stays 3, overrun=1, hex_out=5. Pulse clr_overrun: overrun=0.
- seg_in=7'h55 (illegal): invalid=1, hex_valid=0, hex_out=0, event with ev_invalid=1. Then 0E: hex_out=F, event ev_code=F.
- Assert reset mid-SETTLE with ev_valid=1: all outputs return to reset values within the reset cycle, and no event appears after release while seg_in=7F.
